// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, state enum and rcon helper
//
// Contents:
//   AES_NR_128 : number of rounds for AES-128 (last round-key index)
//   ks_state_t : key-schedule FSM states IDLE / STREAM / FIN
//   xtime()    : GF(2^8) multiply-by-2, used to advance rcon
//                (01,02,04,08,10,20,40,80,1b,36)

package aes_pkg;

    localparam int AES_NR_128 = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } ks_state_t;

    // Left shift, folding the carried-out bit back in with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sub_word.sv
// rtl/key_sub_word.sv - combinational AES SubWord, four parallel S-box byte lookups
//
// Ports:
//   word_in  in  32  word to substitute, byte 0 = word_in[31:24]
//   word_out out 32  S-box applied independently to each byte

module key_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Forward AES S-box; element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        word_out[31:24] = SBOX[word_in[31:24]];
        word_out[23:16] = SBOX[word_in[23:16]];
        word_out[15:8]  = SBOX[word_in[15:8]];
        word_out[7:0]   = SBOX[word_in[7:0]];
    end

endmodule

// File: rtl/key_schedule_gen.sv
// rtl/key_schedule_gen.sv - sequential AES-128 key expansion streaming round keys 0..NUM_ROUNDS
//
// Ports:
//   clk        in   1    clock, all state on posedge
//   rst_n      in   1    asynchronous active-low reset
//   key_in     in   128  cipher key, byte 0 = key_in[127:120]; sampled on key_load && key_ready
//   key_load   in   1    start an expansion
//   key_ready  out  1    high only in IDLE
//   round_key  out  128  current round key (registered)
//   round_idx  out  4    index of round_key
//   rk_valid   out  1    round_key/round_idx valid
//   rk_ready   in   1    consumer accepts round_key
//   done       out  1    one-cycle pulse after the last round key is accepted
//   abort      in   1    only when KEY_SCHED_ABORT_EN is defined: return to IDLE from STREAM/FIN
//
// Optional feature macro: KEY_SCHED_ABORT_EN

module key_schedule_gen
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR_128,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    output logic             key_ready,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             done
`ifdef KEY_SCHED_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [7:0]       rcon_q, rcon_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, t_word;
    logic [31:0] n0, n1, n2, n3;

    // Next round key from the current one: words chain left to right.
    assign w0     = key_q[127:96];
    assign w1     = key_q[95:64];
    assign w2     = key_q[63:32];
    assign w3     = key_q[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};

    key_sub_word u_sub_word (
        .word_in  (rot_w3),
        .word_out (sub_w3)
    );

    assign t_word = sub_w3 ^ {rcon_q, 24'h000000};
    assign n0     = w0 ^ t_word;
    assign n1     = w1 ^ n0;
    assign n2     = w2 ^ n1;
    assign n3     = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        rcon_d  = rcon_q;

        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Nothing moves while the consumer stalls.
                if (valid_q && rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        key_d  = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

`ifdef KEY_SCHED_ABORT_EN
        // Abort wins over a same-cycle handshake: the key/index are left as they were.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            key_d   = key_q;
            idx_d   = idx_q;
            rcon_d  = rcon_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= 4'd0;
            valid_q <= 1'b0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            rcon_q  <= rcon_d;
        end
    end

    assign key_ready = (state_q == IDLE);
    assign done      = (state_q == FIN);
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign rk_valid  = valid_q;

endmodule
